// File: rtl/axi_mem_slave.sv
// Single-port word memory terminating the simplified AXI bus: one outstanding
// transaction, write priority on address collision, programmable read wait states.
module axi_mem_slave #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic              b_valid,
    input  logic              b_ready
);

    typedef enum logic [2:0] {
        StIdle,
        StWrData,
        StWrResp,
        StRdWait,
        StRdData
    } state_e;

    localparam logic [3:0] WcntInit = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wcnt_q;
    logic              addr_rdy_q;
    logic              wdata_ready_q;
    logic              rdata_valid_q;
    logic              b_valid_q;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // addr_rdy_q is cleared by reset and only set by a clock edge, so the
    // readies stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            wcnt_q        <= '0;
            addr_rdy_q    <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            b_valid_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    addr_rdy_q <= 1'b1;
                    if (addr_rdy_q && aw_valid) begin
                        addr_q        <= mem_addr;
                        addr_rdy_q    <= 1'b0;
                        wdata_ready_q <= 1'b1;
                        state_q       <= StWrData;
                    end else if (addr_rdy_q && ar_valid) begin
                        addr_q     <= mem_addr;
                        addr_rdy_q <= 1'b0;
                        if (RD_WAIT == 0) begin
                            rdata_valid_q <= 1'b1;
                            state_q       <= StRdData;
                        end else begin
                            wcnt_q  <= WcntInit;
                            state_q <= StRdWait;
                        end
                    end
                end
                StWrData: begin
                    if (wdata_valid) begin
                        wdata_ready_q <= 1'b0;
                        b_valid_q     <= 1'b1;
                        state_q       <= StWrResp;
                    end
                end
                StWrResp: begin
                    if (b_ready) begin
                        b_valid_q  <= 1'b0;
                        addr_rdy_q <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                StRdWait: begin
                    if (wcnt_q == 4'd0) begin
                        rdata_valid_q <= 1'b1;
                        state_q       <= StRdData;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                StRdData: begin
                    if (rdata_ready) begin
                        rdata_valid_q <= 1'b0;
                        addr_rdy_q    <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Memory has no reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (state_q == StWrData && wdata_valid) begin
            mem[addr_q] <= mem_data;
        end
    end

    assign aw_ready    = addr_rdy_q & reset;
    assign ar_ready    = addr_rdy_q & reset;
    assign wdata_ready = wdata_ready_q;
    assign rdata_valid = rdata_valid_q;
    assign b_valid     = b_valid_q;
    assign mem_data    = rdata_valid_q ? mem[addr_q] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: one instance with no read wait states, one with three.
module tb_axi_mem_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  addr;
    logic [1:0]  awv, arv, wv, rr, br;
    wire  [1:0]  aw_rdy, ar_rdy, wd_rdy, rv, bv;
    logic [31:0] tb_drv;
    logic        tb_oe;
    wire  [31:0] md0, md1;
    int          tests = 0;
    int          fails = 0;

    assign md0 = tb_oe ? tb_drv : 32'hzzzz_zzzz;
    assign md1 = tb_oe ? tb_drv : 32'hzzzz_zzzz;

    always #5 clk = ~clk;

    axi_mem_slave #(.DATA_W(32), .ADDR_W(7), .RD_WAIT(0)) dut0 (
        .clk(clk), .reset(rst_n), .mem_data(md0), .mem_addr(addr),
        .ar_valid(arv[0]), .ar_ready(ar_rdy[0]), .aw_valid(awv[0]), .aw_ready(aw_rdy[0]),
        .wdata_valid(wv[0]), .wdata_ready(wd_rdy[0]), .rdata_valid(rv[0]),
        .rdata_ready(rr[0]), .b_valid(bv[0]), .b_ready(br[0])
    );

    axi_mem_slave #(.DATA_W(32), .ADDR_W(7), .RD_WAIT(3)) dut1 (
        .clk(clk), .reset(rst_n), .mem_data(md1), .mem_addr(addr),
        .ar_valid(arv[1]), .ar_ready(ar_rdy[1]), .aw_valid(awv[1]), .aw_ready(aw_rdy[1]),
        .wdata_valid(wv[1]), .wdata_ready(wd_rdy[1]), .rdata_valid(rv[1]),
        .rdata_ready(rr[1]), .b_valid(bv[1]), .b_ready(br[1])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bus(input int i);
        return (i == 1) ? md1 : md0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Drive 0 on the bus; it reads back 0 only if the slave has let go.
    task automatic check_released(input string tag, input int i);
        tb_drv = 32'h0;
        tb_oe  = 1'b1;
        #1;
        check(tag, bus(i), 32'h0);
        tb_oe  = 1'b0;
    endtask

    task automatic wait_aw(input int i);
        int n = 0;
        while (!aw_rdy[i] && n < 20) begin
            tick();
            n++;
        end
        check("aw_ready wait", {31'b0, aw_rdy[i]}, 32'd1);
    endtask

    task automatic wait_ar(input int i);
        int n = 0;
        while (!ar_rdy[i] && n < 20) begin
            tick();
            n++;
        end
        check("ar_ready wait", {31'b0, ar_rdy[i]}, 32'd1);
    endtask

    task automatic do_write(input int i, input logic [6:0] a, input logic [31:0] d,
                            input int bwait);
        addr   = a;
        awv[i] = 1'b1;
        wait_aw(i);
        tick();
        awv[i] = 1'b0;
        check("wdata_ready after AW", {31'b0, wd_rdy[i]}, 32'd1);
        check("aw_ready drop", {31'b0, aw_rdy[i]}, 32'd0);
        check("no read during write", {31'b0, rv[i]}, 32'd0);
        wv[i]  = 1'b1;
        tb_drv = d;
        tb_oe  = 1'b1;
        tick();
        wv[i]  = 1'b0;
        tb_oe  = 1'b0;
        check("b_valid after W", {31'b0, bv[i]}, 32'd1);
        check("wdata_ready drop", {31'b0, wd_rdy[i]}, 32'd0);
        repeat (bwait) begin
            tick();
            check("b_valid held", {31'b0, bv[i]}, 32'd1);
        end
        br[i] = 1'b1;
        tick();
        br[i] = 1'b0;
        check("b_valid drop", {31'b0, bv[i]}, 32'd0);
        check("aw_ready after B", {31'b0, aw_rdy[i]}, 32'd1);
    endtask

    task automatic do_read(input int i, input logic [6:0] a, input logic [31:0] exp,
                           input int rwait, input int lat);
        addr   = a;
        arv[i] = 1'b1;
        wait_ar(i);
        tick();
        arv[i] = 1'b0;
        repeat (lat) begin
            check("rdata_valid during wait", {31'b0, rv[i]}, 32'd0);
            tick();
        end
        check("rdata_valid rise", {31'b0, rv[i]}, 32'd1);
        check("rdata", bus(i), exp);
        repeat (rwait) begin
            tick();
            check("rdata_valid held", {31'b0, rv[i]}, 32'd1);
            check("rdata held", bus(i), exp);
        end
        rr[i] = 1'b1;
        tick();
        rr[i] = 1'b0;
        check("rdata_valid drop", {31'b0, rv[i]}, 32'd0);
        check("ar_ready after R", {31'b0, ar_rdy[i]}, 32'd1);
        check_released("bus released after R", i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; addr = '0; awv = '0; arv = '0; wv = '0; rr = '0; br = '0;
        tb_drv = '0; tb_oe = 1'b0;
        repeat (2) tick();
        check("rst aw_ready", {31'b0, aw_rdy[0]}, 32'd0);
        check("rst ar_ready", {31'b0, ar_rdy[0]}, 32'd0);
        check("rst wdata_ready", {31'b0, wd_rdy[0]}, 32'd0);
        check("rst rdata_valid", {31'b0, rv[0]}, 32'd0);
        check("rst b_valid", {31'b0, bv[0]}, 32'd0);
        check_released("rst bus released", 0);
        rst_n = 1'b1;
        #1;
        check("ready before first edge", {31'b0, ar_rdy[0]}, 32'd0);
        tick();
        check("aw_ready after release", {31'b0, aw_rdy[0]}, 32'd1);
        check("ar_ready after release", {31'b0, ar_rdy[0]}, 32'd1);

        do_write(0, 7'h05, 32'hDEAD_BEEF, 2);
        do_read(0, 7'h05, 32'hDEAD_BEEF, 3, 0);

        // Collision: read is held pending while the write goes first.
        arv[0] = 1'b1;
        do_write(0, 7'h10, 32'h1234_5678, 0);
        do_read(0, 7'h10, 32'h1234_5678, 0, 0);

        do_write(0, 7'h7F, 32'hA5A5_A5A5, 0);
        do_write(0, 7'h00, 32'h5A5A_5A5A, 0);
        do_read(0, 7'h7F, 32'hA5A5_A5A5, 0, 0);
        do_read(0, 7'h00, 32'h5A5A_5A5A, 0, 0);

        do_write(1, 7'h05, 32'hDEAD_BEEF, 0);
        do_read(1, 7'h05, 32'hDEAD_BEEF, 1, 3);

        // Reset while in RD_DATA.
        addr   = 7'h05;
        arv[0] = 1'b1;
        wait_ar(0);
        tick();
        arv[0] = 1'b0;
        check("pre-reset rdata_valid", {31'b0, rv[0]}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset rdata_valid", {31'b0, rv[0]}, 32'd0);
        check("reset ar_ready", {31'b0, ar_rdy[0]}, 32'd0);
        check_released("reset bus released", 0);
        tick();
        check("reset aw_ready held", {31'b0, aw_rdy[0]}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("release aw_ready still 0", {31'b0, aw_rdy[0]}, 32'd0);
        tick();
        check("aw_ready after 2nd release", {31'b0, aw_rdy[0]}, 32'd1);

        // Reset in WR_DATA before the data handshake must not write.
        addr   = 7'h05;
        awv[0] = 1'b1;
        wait_aw(0);
        tick();
        awv[0] = 1'b0;
        check("wr_data before reset", {31'b0, wd_rdy[0]}, 32'd1);
        wv[0]  = 1'b1;
        tb_drv = 32'h0BAD_F00D;
        tb_oe  = 1'b1;
        rst_n  = 1'b0;
        #1;
        check("reset wdata_ready", {31'b0, wd_rdy[0]}, 32'd0);
        tick();
        wv[0] = 1'b0;
        tb_oe = 1'b0;
        rst_n = 1'b1;
        tick();
        do_read(0, 7'h05, 32'hDEAD_BEEF, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
# axi_mem_slave

- Single-port 128×32 memory slave that terminates the simplified AXI bus carried by `axi_if`.
- It sits directly downstream of the interface and services the read and write transactions issued by the testbench driver.
- It answers the address handshakes, accepts write data and returns a write response, and drives read data onto the shared bidirectional data bus.
- Read data can be delayed by a programmable number of wait states, to exercise driver back-pressure handling.

## Interface

Parameters:
- `DATA_W`, 32, data width; width of `mem_data` and of each memory word.
- `ADDR_W`, 7, word address width; memory depth is 2**ADDR_W words.
- `RD_WAIT`, 0, wait cycles inserted between AR handshake and `rdata_valid` (legal range 0..15).

Ports:
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_data`  inout  DATA_W  shared data bus. Driven by the slave only in RD_DATA, high-Z otherwise.
- `mem_addr`  in  ADDR_W  word address, sampled on AR or AW handshake.
- `ar_valid`  in  1  read address valid.
- `ar_ready`  out  1  read address ready.
- `aw_valid`  in  1  write address valid.
- `aw_ready`  out  1  write address ready.
- `wdata_valid`  in  1  write data valid (master drives `mem_data`).
- `wdata_ready`  out  1  write data ready.
- `rdata_valid`  out  1  read data valid (slave drives `mem_data`).
- `rdata_ready`  in  1  read data accepted.
- `b_valid`  out  1  write response valid.
- `b_ready`  in  1  write response accepted.

## Operation

- Handshake: a transfer completes on a rising edge where valid and ready are both 1.
- FSM states:
  - IDLE
  - WR_DATA
  - WR_RESP
  - RD_WAIT
  - RD_DATA
- Registered address `addr_q` (ADDR_W bits); wait counter `wcnt_q` (4 bits).
- IDLE: `aw_ready`=`ar_ready`=1.
  - If `aw_valid`=1: latch `mem_addr`, go to WR_DATA. Write wins when `aw_valid` and `ar_valid` arrive together.
  - Else if `ar_valid`=1: latch `mem_addr`. If RD_WAIT=0 go to RD_DATA, otherwise load `wcnt_q`=RD_WAIT-1 and go to RD_WAIT.
  - An `ar_valid` that loses arbitration stays pending: the master holds it, and it is serviced on the next return to IDLE.
- WR_DATA: `wdata_ready`=1. On handshake, `mem[addr_q]` ← `mem_data`, go to WR_RESP. `wdata_valid` seen in any other state is ignored.
- WR_RESP: `b_valid`=1, held until `b_ready`=1, then go to IDLE.
- RD_WAIT: decrement `wcnt_q`. When `wcnt_q`=0, go to RD_DATA.
- RD_DATA:
  - `rdata_valid`=1 and `mem_data`=`mem[addr_q]`.
  - Both are held stable until `rdata_ready`=1, then go to IDLE.
- All handshake outputs are decoded from registered state only; no input-to-output combinational paths.
- Ready outputs are ANDed with `reset`, so they read 0 while reset is asserted.
- Address arithmetic:
  - Full ADDR_W decode; no out-of-range addresses exist.
  - Addresses 0x00 and 0x7F are distinct words.
- Memory array is not cleared by reset. Contents survive reset and are X until first written.

## Timing

- Reset (asynchronous assert, synchronous release on the next `clk` edge):
  - State goes to IDLE.
  - `aw_ready`=`ar_ready`=0 while asserted.
  - `wdata_ready`=`rdata_valid`=`b_valid`=0.
  - `mem_data` released to high-Z.
- First edge after deassert: `aw_ready`=`ar_ready`=1.
- Reset asserted mid-transaction abandons it immediately:
  - A write in WR_RESP has already updated memory.
  - A write in WR_DATA without a handshake leaves memory unchanged.
- Write latency:
  - AW handshake at edge N gives `wdata_ready`=1 in cycle N+1.
  - Data handshake at edge M gives `b_valid`=1 in cycle M+1.
  - Minimum write is 3 cycles.
- Read latency: AR handshake at edge N gives `rdata_valid`=1 and valid `mem_data` in cycle N+1+RD_WAIT.
- `aw_ready`/`ar_ready` drop in the cycle after the handshake. No new address is accepted until the current transaction completes; one outstanding transaction maximum.
- Back-to-back: after the B or R handshake at edge K, IDLE readies are 1 in cycle K+1.
- Bus turnaround: the slave stops driving `mem_data` in the cycle after the R handshake. The master must not drive it while `rdata_valid`=1.

## Test plan

- Write 0xDEADBEEF to addr 0x05:
  - `wdata_ready` rises 1 cycle after AW handshake.
  - `b_valid` rises 1 cycle after the data handshake.
  - With `b_ready` held low for 2 cycles, `b_valid` stays 1 and drops the cycle after `b_ready`=1.
- Read addr 0x05 (RD_WAIT=0), `rdata_ready` low for 3 cycles:
  - `rdata_valid` rises the cycle after AR handshake.
  - `mem_data`=0xDEADBEEF is held stable all 4 cycles, then goes high-Z.
- Simultaneous `aw_valid`+`ar_valid` at addr 0x10, write data 0x12345678:
  - Write completes first.
  - Held read then returns 0x12345678.
- RD_WAIT=3, read addr 0x05: `rdata_valid` first asserts exactly 4 cycles after the AR handshake.
- Write 0xA5A5A5A5 to 0x7F and 0x5A5A5A5A to 0x00; reading both returns the respective values (no aliasing).
- Assert `reset` while in RD_DATA:
  - `rdata_valid`=0 and `mem_data` high-Z immediately.
  - Readies stay 0 until the first edge after release.
  - Re-reading 0x05 returns 0xDEADBEEF.
